piso_stream: RTL and testbench
==============================

PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 SHALL have parameter WORD_W, default 16: FIFO word width.
REQ-002 SHALL have parameter SYM_W, default 2: output symbol width; WORD_W SHALL be a multiple of SYM_W, with N = WORD_W/SYM_W >= 2.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = most-significant symbol first, 0 = least-significant symbol first.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port fifo_data_i  input  WORD_W  FIFO read data, valid the cycle after fifo_rd_en_o is high.
REQ-007 SHALL have port fifo_empty_i  input  1  FIFO empty flag.
REQ-008 SHALL have port fifo_rd_en_o  output  1  FIFO read strobe, one-cycle pulse per word.
REQ-009 SHALL have port data_o  output  SYM_W  symbol to the Viterbi core.
REQ-010 SHALL have port valid_o  output  1  data_o valid.
REQ-011 SHALL have port ready_i  input  1  downstream accept; a transfer occurs on valid_o && ready_i.
REQ-012 SHALL have port last_o  output  1  high with the last symbol of each word.
REQ-013 SHALL have port busy_o  output  1  high when state != IDLE or a prefetched word is held.

Function
REQ-014 SHALL implement states IDLE, READ_WAIT and SHIFT; any other encoding SHALL go to IDLE.
REQ-015 IDLE: when !fifo_empty_i, SHALL pulse fifo_rd_en_o and go to READ_WAIT; valid_o SHALL be 0.
REQ-016 READ_WAIT: SHALL load fifo_data_i, present the first symbol with valid_o=1 at the next edge, set the remaining count to N-1, and go to SHIFT.
REQ-017 SHIFT: on each transfer with count>0, SHALL present the next symbol and decrement count.
REQ-018 SHIFT: on the transfer of the last symbol (count=0), SHALL reload as per REQ-025 when the prefetch macro is defined, otherwise drop valid_o and go to IDLE.
REQ-019 Symbol order: MSB_FIRST=1 SHALL emit word[WORD_W-1 -: SYM_W] first; MSB_FIRST=0 SHALL emit word[SYM_W-1:0] first.
REQ-020 While valid_o=1 && ready_i=0, data_o, last_o and valid_o SHALL hold stable for any number of cycles.
REQ-021 fifo_rd_en_o SHALL never be asserted while fifo_empty_i=1.
REQ-022 At most one FIFO read SHALL be outstanding or held at any time; no word SHALL be dropped or duplicated.
REQ-023 last_o SHALL equal valid_o && (count==0).

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, fifo_rd_en_o=0, data_o=0, valid_o=0, last_o=0, busy_o=0, count=0, shift and hold registers=0, hold flag=0. Any partial word SHALL be discarded, and operation SHALL restart from IDLE after release.

Configuration
REQ-025 Macro PISO_PREFETCH_EN defined: in SHIFT, when !fifo_empty_i, no read is pending and no word is held, the block SHALL pulse fifo_rd_en_o, capture the returned word in a hold register, and on transfer of the last symbol load the next word from the hold register (or directly from fifo_data_i if it returns that cycle), keeping valid_o=1 with zero bubble cycles.
REQ-026 Macro PISO_PREFETCH_EN undefined: no hold register; every word SHALL pass through IDLE and READ_WAIT, giving exactly 2 valid_o=0 cycles between words when ready_i=1.

Verification
REQ-027 WORD_W=16, SYM_W=2, MSB_FIRST=1, word 16'hA5C3, ready_i=1 -> data_o sequence 2,2,1,1,3,0,0,3; last_o high only on the final 3; exactly one fifo_rd_en_o pulse.
REQ-028 MSB_FIRST=0, word 16'hA5C3 -> data_o sequence 3,0,0,3,1,1,2,2.
REQ-029 Two words queued, ready_i=1: with PISO_PREFETCH_EN -> 16 consecutive valid_o cycles; without it -> 8 valid, 2 idle, 8 valid.
REQ-030 ready_i=0 for 3 cycles while the 3rd symbol of 16'hA5C3 is presented -> data_o=1 and valid_o=1 held for 3 cycles; no extra fifo_rd_en_o; the remaining sequence is unchanged.
REQ-031 rst_n pulsed low after the 3rd symbol, with fifo_empty_i=1 after release -> all outputs 0 immediately, state stays IDLE, and no fifo_rd_en_o is issued.
REQ-032 fifo_empty_i=1 throughout -> fifo_rd_en_o, valid_o and busy_o remain 0 for 100 cycles.

Source files
------------

// File: rtl/piso_stream.sv
// ----------------------------------------------------------------------------
// piso_stream
//
// Purpose:
//   Parallel-in / serial-out adapter between a show-ahead-less FIFO and a
//   symbol-oriented consumer (Viterbi core). Each WORD_W-bit FIFO word is
//   read with a one-cycle strobe. The returned data (valid one cycle after
//   the strobe) is split into N = WORD_W/SYM_W symbols. These symbols are
//   streamed out over a valid/ready handshake, MSB-first or LSB-first.
//
// Parameters:
//   WORD_W    FIFO word width (multiple of SYM_W, N >= 2)
//   SYM_W     output symbol width
//   MSB_FIRST 1 = most-significant symbol first, 0 = least-significant first
//
// Configuration macro:
//   PISO_PREFETCH_EN  when defined, the next word is fetched while the current
//                     one is still shifting. It is parked in a hold register,
//                     so back-to-back words stream with no idle cycles. When
//                     undefined, every word goes IDLE -> READ_WAIT -> SHIFT.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   fifo_data_i   FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_empty_i  FIFO empty flag
//   fifo_rd_en_o  FIFO read strobe, one-cycle pulse per word
//   data_o        current output symbol
//   valid_o       data_o valid
//   ready_i       downstream accept (transfer on valid_o && ready_i)
//   last_o        marks the final symbol of each word
//   busy_o        high when not IDLE or a prefetched word is held
// ----------------------------------------------------------------------------
module piso_stream #(
    parameter int WORD_W    = 16,
    parameter int SYM_W     = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] fifo_data_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    output logic [SYM_W-1:0]  data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              busy_o
);

    localparam int N     = WORD_W / SYM_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    // Remaining-symbol count loaded when a fresh word enters the shifter.
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_READ_WAIT = 2'b01,
        S_SHIFT     = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_shift_next;
    logic [WORD_W-1:0] w_shift_adv;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              r_valid;
    logic              w_valid_next;

    logic              w_xfer;
    logic              w_last_xfer;
    logic              w_rd_idle;
    logic              w_rd_pf;

`ifdef PISO_PREFETCH_EN
    // r_pending: a prefetch strobe was issued last cycle, so fifo_data_i
    // carries that word in the current cycle.
    logic              r_pending;
    logic              w_pending_next;
    logic [WORD_W-1:0] r_hold;
    logic [WORD_W-1:0] w_hold_next;
    logic              r_hold_valid;
    logic              w_hold_valid_next;
`endif

    // ------------------------------------------------------------------
    // Handshake and read-strobe decode
    // ------------------------------------------------------------------
    assign w_xfer      = r_valid && ready_i;
    assign w_last_xfer = w_xfer && (r_count == '0);
    assign w_rd_idle   = (r_state == S_IDLE) && !fifo_empty_i;

`ifdef PISO_PREFETCH_EN
    // Only one word may be in flight or parked at a time. A prefetch is
    // therefore suppressed while a read is returning or a word is held.
    assign w_rd_pf = (r_state == S_SHIFT) && !fifo_empty_i &&
                     !r_pending && !r_hold_valid;
`else
    assign w_rd_pf = 1'b0;
`endif

    // The strobe is combinational from the state and empty flag. It is
    // therefore qualified with rst_n to stay low throughout reset, even
    // when the FIFO is not empty.
    assign fifo_rd_en_o = rst_n & (w_rd_idle | w_rd_pf);

    // ------------------------------------------------------------------
    // Symbol selection: the outgoing symbol always sits at one end of the
    // shift register, and each transfer shifts the next one into place.
    // ------------------------------------------------------------------
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_adv = {r_shift[WORD_W-SYM_W-1:0], {SYM_W{1'b0}}};
            assign data_o      = r_shift[WORD_W-1 -: SYM_W];
        end else begin : g_lsb_first
            assign w_shift_adv = {{SYM_W{1'b0}}, r_shift[WORD_W-1:SYM_W]};
            assign data_o      = r_shift[SYM_W-1:0];
        end
    endgenerate

    assign valid_o = r_valid;
    assign last_o  = r_valid && (r_count == '0);

`ifdef PISO_PREFETCH_EN
    assign busy_o = (r_state != S_IDLE) || r_hold_valid;
`else
    assign busy_o = (r_state != S_IDLE);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_count_next = r_count;
        w_valid_next = r_valid;
`ifdef PISO_PREFETCH_EN
        w_pending_next    = w_rd_pf;
        w_hold_next       = r_hold;
        w_hold_valid_next = r_hold_valid;
`endif

        case (r_state)
            S_IDLE: begin
                w_valid_next = 1'b0;
                if (!fifo_empty_i) begin
                    w_state_next = S_READ_WAIT;
                end
            end

            S_READ_WAIT: begin
                // Data for the strobe issued last cycle is on fifo_data_i now.
                w_shift_next = fifo_data_i;
                w_count_next = CNT_RELOAD;
                w_valid_next = 1'b1;
                w_state_next = S_SHIFT;
            end

            S_SHIFT: begin
`ifdef PISO_PREFETCH_EN
                // Park a returning prefetch unless it is consumed directly
                // by a reload in this same cycle.
                if (r_pending && !w_last_xfer) begin
                    w_hold_next       = fifo_data_i;
                    w_hold_valid_next = 1'b1;
                end
`endif
                if (w_xfer) begin
                    w_shift_next = w_shift_adv;
                    if (r_count != '0) begin
                        w_count_next = r_count - 1'b1;
                    end else begin
`ifdef PISO_PREFETCH_EN
                        if (r_hold_valid) begin
                            w_shift_next      = r_hold;
                            w_count_next      = CNT_RELOAD;
                            w_hold_valid_next = 1'b0;
                        end else if (r_pending) begin
                            w_shift_next = fifo_data_i;
                            w_count_next = CNT_RELOAD;
                        end else if (w_rd_pf) begin
                            // A read launched this very cycle returns next
                            // cycle, which is exactly what READ_WAIT expects.
                            w_valid_next = 1'b0;
                            w_state_next = S_READ_WAIT;
                        end else begin
                            w_valid_next = 1'b0;
                            w_state_next = S_IDLE;
                        end
`else
                        w_valid_next = 1'b0;
                        w_state_next = S_IDLE;
`endif
                    end
                end
            end

            default: begin
                w_valid_next = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            r_shift <= w_shift_next;
            r_count <= w_count_next;
            r_valid <= w_valid_next;
        end
    end

`ifdef PISO_PREFETCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending    <= 1'b0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_pending    <= w_pending_next;
            r_hold       <= w_hold_next;
            r_hold_valid <= w_hold_valid_next;
        end
    end
`endif

endmodule

// File: tb/tb_piso_stream.sv
// ----------------------------------------------------------------------------
// tb_piso_stream
//
// Purpose:
//   Scoreboard bench for piso_stream. An MSB-first and an LSB-first instance
//   share one FIFO model and one ready_i. Their control behaviour must be
//   identical, while their symbol order differs. Stimulus pushes FIFO words
//   and their hand-computed symbol sequences into a queue. A negedge monitor
//   pops and compares on every transfer and also checks hold stability and
//   read-strobe legality. Honours PISO_PREFETCH_EN for the inter-word gap.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_piso_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] fifo_data_i = 16'h0000;
    logic        fifo_empty_i;
    logic        ready_i = 1'b1;

    logic        rd_en, valid, last, busy;
    logic [1:0]  data;
    logic        lsb_rd_en, lsb_valid, lsb_last, lsb_busy;
    logic [1:0]  lsb_data;

    always #5 clk = ~clk;

    piso_stream #(.WORD_W(16), .SYM_W(2), .MSB_FIRST(1)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_en_o (rd_en),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready_i),
        .last_o       (last),
        .busy_o       (busy)
    );

    piso_stream #(.WORD_W(16), .SYM_W(2), .MSB_FIRST(0)) u_lsb (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_en_o (lsb_rd_en),
        .data_o       (lsb_data),
        .valid_o      (lsb_valid),
        .ready_i      (ready_i),
        .last_o       (lsb_last),
        .busy_o       (lsb_busy)
    );

`ifdef PISO_PREFETCH_EN
    localparam int EXP_GAP = 1;
`else
    localparam int EXP_GAP = 3;
`endif

    // Directed words and hand-decoded 2-bit symbol sequences.
    logic [15:0] words [3] = '{16'hA5C3, 16'h1234, 16'h0F96};
    int msb_tab [3][8] = '{'{2,2,1,1,3,0,0,3}, '{0,1,0,2,0,3,1,0}, '{0,0,3,3,2,1,1,2}};
    int lsb_tab [3][8] = '{'{3,0,0,3,1,1,2,2}, '{0,1,3,0,2,0,1,0}, '{2,1,1,2,3,3,0,0}};

    typedef struct packed {
        logic [1:0] msb;
        logic [1:0] lsb;
        logic       last;
    } exp_t;

    exp_t exp_q [$];
    int   xfer_cyc [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int xfer_total = 0;

    // FIFO model: stimulus owns wr_ptr/mem, the pop process owns rd_ptr.
    logic [15:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty_i = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en && (wr_ptr != rd_ptr)) begin
            fifo_data_i <= mem[rd_ptr % 64];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_word(input int k);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.msb  = 2'(msb_tab[k][i]);
            e.lsb  = 2'(lsb_tab[k][i]);
            e.last = (i == 7);
            exp_q.push_back(e);
        end
        mem[wr_ptr % 64] = words[k];
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && !busy && !valid) && n < 300);
        chk({name, "_drain_timeout"}, (n >= 300) ? 1 : 0, 0);
    endtask

    task automatic wait_xfers(input string name, input int target);
        int n;
        n = 0;
        while (xfer_total < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_xfer_timeout"}, (n >= 100) ? 1 : 0, 0);
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    logic       stall_prev = 1'b0;
    logic [1:0] prev_data = '0;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                rd_cnt++;
                chk("rd_en_while_empty", int'(fifo_empty_i), 0);
            end
            if (lsb_rd_en != rd_en) chk("lsb_rd_en_match", int'(lsb_rd_en), int'(rd_en));
            if (lsb_valid != valid) chk("lsb_valid_match", int'(lsb_valid), int'(valid));
            if (last && !valid) chk("last_without_valid", int'(last), 0);
            if (stall_prev) begin
                chk("stall_valid_hold", int'(valid), 1);
                chk("stall_data_hold", int'(data), int'(prev_data));
                chk("stall_last_hold", int'(last), int'(prev_last));
            end
            if (valid && ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("msb_data", int'(data), int'(e.msb));
                    chk("msb_last", int'(last), int'(e.last));
                    chk("lsb_data", int'(lsb_data), int'(e.lsb));
                    chk("lsb_last", int'(lsb_last), int'(e.last));
                end
                $display("xfer cyc=%0d data=%0d last=%0d lsb_data=%0d lsb_last=%0d",
                         cyc, data, last, lsb_data, lsb_last);
                xfer_cyc.push_back(cyc);
                xfer_total++;
            end
            stall_prev = valid && !ready_i;
            prev_data  = data;
            prev_last  = last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int base;
        int bad;
        int noncontig;
        logic [7:0] pat;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_data", int'(data), 0);
        chk("reset_last", int'(last), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_lsb_valid_busy", int'(lsb_valid | lsb_busy), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Empty FIFO for 100 cycles: nothing may happen
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (rd_en || valid || busy || lsb_rd_en || lsb_valid || lsb_busy) bad++;
        end
        chk("idle100_activity", bad, 0);

        // Single word A5C3, ready held high
        @(posedge clk); #1;
        rd_cnt = 0;
        base = xfer_cyc.size();
        push_word(0);
        drain("single");
        chk("single_rd_pulses", rd_cnt, 1);
        chk("single_xfers", xfer_cyc.size() - base, 8);
        if (xfer_cyc.size() - base == 8)
            chk("single_contiguous", xfer_cyc[base+7] - xfer_cyc[base], 7);

        // Two words queued together
        @(posedge clk); #1;
        rd_cnt = 0;
        base = xfer_cyc.size();
        push_word(1);
        push_word(2);
        drain("two_words");
        chk("two_rd_pulses", rd_cnt, 2);
        chk("two_xfers", xfer_cyc.size() - base, 16);
        if (xfer_cyc.size() - base == 16) begin
            noncontig = 0;
            for (int i = 1; i < 16; i++)
                if (i != 8 && xfer_cyc[base+i] - xfer_cyc[base+i-1] != 1) noncontig++;
            chk("two_intra_word_gaps", noncontig, 0);
            chk("two_inter_word_gap", xfer_cyc[base+8] - xfer_cyc[base+7], EXP_GAP);
        end

        // Backpressure on the 3rd symbol of A5C3
        @(posedge clk); #1;
        rd_cnt = 0;
        base = xfer_total;
        push_word(0);
        wait_xfers("stall", base + 2);
        @(posedge clk); #1 ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_sym3_valid", int'(valid), 1);
            chk("stall_sym3_data", int'(data), 1);
        end
        @(posedge clk); #1 ready_i = 1'b1;
        drain("stall");
        chk("stall_rd_pulses", rd_cnt, 1);

        // Reset in the middle of a word
        @(posedge clk); #1;
        base = xfer_total;
        push_word(0);
        wait_xfers("midreset", base + 2);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midreset_valid", int'(valid), 0);
        chk("midreset_data", int'(data), 0);
        chk("midreset_last", int'(last), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_rd_en", int'(rd_en), 0);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_en || valid || busy || last || data != 2'd0) bad++;
        end
        chk("post_reset_idle", bad, 0);

        // Three words with an irregular ready pattern
        @(posedge clk); #1;
        rd_cnt = 0;
        pat = 8'b1011_0110;
        push_word(1);
        push_word(0);
        push_word(2);
        for (int n = 0; n < 400 && (exp_q.size() != 0 || busy); n++) begin
            @(posedge clk); #1 ready_i = pat[cyc % 8];
        end
        ready_i = 1'b1;
        drain("bursty");
        chk("bursty_rd_pulses", rd_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
